// File: rtl/bcd_score_counter.sv
// bcd_score_counter
//
// Packed-BCD game score counter. Frame ticks (optionally divided by a
// prescaler) and bonus events are summed into a DIGITS-wide BCD score while
// a game is running. Overflow past all-nines either wraps or saturates, and
// raises a sticky flag that clears at the next game start. The best finished
// score is kept in hi_score across games; only rst clears it.
//
// Parameters:
//   DIGITS    number of BCD digits (>= 1)
//   TICK_DIV  game ticks per +1 score (>= 1)
//   BONUS_POS digit index at which bonus_amount is added
//   WRAP      1 = wrap modulo 10^DIGITS, 0 = saturate at all-nines
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   game_start   pulse: begin (or restart) a game
//   game_over    pulse: end the running game
//   game_tick    pulse: end of frame
//   bonus_valid  pulse: add bonus_amount at digit BONUS_POS
//   bonus_amount bonus digit, 10..15 treated as 9
//   score        packed BCD score, digit 0 in the LSBs
//   hi_score     packed BCD best finished score
//   game_active  high while a game is running
//   new_high     last finished game beat the previous high score
//   overflow     sticky: score passed all-nines during this game

module bcd_score_counter #(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 1,
    parameter int BONUS_POS = 1,
    parameter int WRAP      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_start,
    input  logic                  game_over,
    input  logic                  game_tick,
    input  logic                  bonus_valid,
    input  logic [3:0]            bonus_amount,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hi_score,
    output logic                  game_active,
    output logic                  new_high,
    output logic                  overflow
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  NINES    = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    score_q, score_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            active_q, active_d;
    logic            new_high_q, new_high_d;
    logic            overflow_q, overflow_d;

    logic            start_evt;
    logic            over_evt;
    logic            count_en;
    logic            unit_inc;
    logic [3:0]      bonus_dig;
    logic [W-1:0]    sum_bcd;
    logic            carry_out;

    // Clamp an out-of-range bonus digit to 9.
    function automatic logic [3:0] sat_bonus(input logic [3:0] a);
        return (a > 4'd9) ? 4'd9 : a;
    endfunction

    // One BCD digit of the ripple adder; returns {carry, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        t = s - 5'd10;
        if (s > 5'd9) begin
            return {1'b1, t[3:0]};
        end
        return {1'b0, s[3:0]};
    endfunction

    // FSM state register plus all other registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            hi_q       <= '0;
            pre_q      <= '0;
            active_q   <= 1'b0;
            new_high_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            hi_q       <= hi_d;
            pre_q      <= pre_d;
            active_q   <= active_d;
            new_high_q <= new_high_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic: game_start always wins over a coincident game_over.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (game_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (game_start)     state_d = ST_RUN;
                else if (game_over) state_d = ST_OVER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: event strobes for the datapath and the active flag.
    always_comb begin
        start_evt = game_start;
        over_evt  = (state_q == ST_RUN) && game_over && !game_start;
        // Ticks and bonuses landing on a start/over cycle are dropped.
        count_en  = (state_q == ST_RUN) && !game_start && !game_over;
        active_d  = (state_d == ST_RUN);
    end

    // Prescaler: the unit increment fires on the tick that wraps it.
    always_comb begin
        unit_inc = 1'b0;
        pre_d    = pre_q;
        if (start_evt) begin
            pre_d = '0;
        end else if (count_en && game_tick) begin
            if (pre_q == PRE_LAST) begin
                pre_d    = '0;
                unit_inc = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    // Ripple BCD adder. The unit increment enters as the carry into digit 0,
    // so digit 0 never sees an addend above 9 even when BONUS_POS is 0.
    always_comb begin
        logic       carry;
        logic [3:0] addend_dig;
        logic [4:0] dig_res;
        bonus_dig = (bonus_valid && count_en) ? sat_bonus(bonus_amount) : 4'd0;
        carry     = unit_inc;
        sum_bcd   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            addend_dig = (i == BONUS_POS) ? bonus_dig : 4'd0;
            dig_res    = bcd_digit_add(score_q[4*i +: 4], addend_dig, carry);
            sum_bcd[4*i +: 4] = dig_res[3:0];
            carry      = dig_res[4];
        end
        carry_out = carry;
    end

    // Score, overflow and high-score update.
    always_comb begin
        score_d    = score_q;
        overflow_d = overflow_q;
        hi_d       = hi_q;
        new_high_d = new_high_q;
        if (start_evt) begin
            score_d    = '0;
            overflow_d = 1'b0;
            new_high_d = 1'b0;
        end else if (over_evt) begin
            // Packed BCD orders the same as unsigned binary; ties do nothing.
            if (score_q > hi_q) begin
                hi_d       = score_q;
                new_high_d = 1'b1;
            end
        end else if (count_en) begin
            if (carry_out) begin
                overflow_d = 1'b1;
                score_d    = (WRAP != 0) ? sum_bcd : NINES;
            end else begin
                score_d = sum_bcd;
            end
        end
    end

    assign score       = score_q;
    assign hi_score    = hi_q;
    assign game_active = active_q;
    assign new_high    = new_high_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Testbench for bcd_score_counter. Four instances with different parameter
// sets share one stimulus stream; an integer-arithmetic model tracks each.

module tb_bcd_score_counter;

    logic       clk = 1'b0;
    logic       in_rst = 1'b0, in_start = 1'b0, in_over = 1'b0;
    logic       in_tick = 1'b0, in_bv = 1'b0;
    logic [3:0] in_amt = 4'd0;

    always #5 clk = ~clk;

    // Instance outputs
    logic [15:0] a_score, a_hi, b_score, b_hi, c_score, c_hi;
    logic [3:0]  d_score, d_hi;
    logic        a_act, a_nh, a_ov, b_act, b_nh, b_ov;
    logic        c_act, c_nh, c_ov, d_act, d_nh, d_ov;

    // A: defaults (4 digits, div 1, bonus at digit 1, saturate)
    bcd_score_counter dut_a (
        .clk(clk), .rst(in_rst), .game_start(in_start), .game_over(in_over),
        .game_tick(in_tick), .bonus_valid(in_bv), .bonus_amount(in_amt),
        .score(a_score), .hi_score(a_hi), .game_active(a_act),
        .new_high(a_nh), .overflow(a_ov));

    // B: wrapping
    bcd_score_counter #(.WRAP(1)) dut_b (
        .clk(clk), .rst(in_rst), .game_start(in_start), .game_over(in_over),
        .game_tick(in_tick), .bonus_valid(in_bv), .bonus_amount(in_amt),
        .score(b_score), .hi_score(b_hi), .game_active(b_act),
        .new_high(b_nh), .overflow(b_ov));

    // C: prescaler of 3
    bcd_score_counter #(.TICK_DIV(3)) dut_c (
        .clk(clk), .rst(in_rst), .game_start(in_start), .game_over(in_over),
        .game_tick(in_tick), .bonus_valid(in_bv), .bonus_amount(in_amt),
        .score(c_score), .hi_score(c_hi), .game_active(c_act),
        .new_high(c_nh), .overflow(c_ov));

    // D: single digit, div 2, bonus at digit 0, wrapping
    bcd_score_counter #(.DIGITS(1), .TICK_DIV(2), .BONUS_POS(0), .WRAP(1)) dut_d (
        .clk(clk), .rst(in_rst), .game_start(in_start), .game_over(in_over),
        .game_tick(in_tick), .bonus_valid(in_bv), .bonus_amount(in_amt),
        .score(d_score), .hi_score(d_hi), .game_active(d_act),
        .new_high(d_nh), .overflow(d_ov));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state, one entry per instance
    int p_dig [4] = '{4, 4, 4, 1};
    int p_div [4] = '{1, 1, 3, 2};
    int p_bp  [4] = '{1, 1, 1, 0};
    int p_wrap[4] = '{0, 1, 0, 1};
    int m_score[4], m_hi[4], m_pre[4];
    bit m_run[4], m_nh[4], m_ov[4];

    function automatic int p10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'((v / p10(d)) % 10);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int add;
            int lim;
            int s;
            add = 0;
            lim = p10(p_dig[i]);
            if (in_rst) begin
                m_run[i] = 0; m_score[i] = 0; m_hi[i] = 0;
                m_pre[i] = 0; m_nh[i] = 0; m_ov[i] = 0;
            end else if (in_start) begin
                m_run[i] = 1; m_score[i] = 0; m_ov[i] = 0; m_nh[i] = 0; m_pre[i] = 0;
            end else if (in_over && m_run[i]) begin
                m_run[i] = 0;
                if (m_score[i] > m_hi[i]) begin
                    m_hi[i] = m_score[i];
                    m_nh[i] = 1;
                end
            end else if (m_run[i] && !in_over) begin
                if (in_tick) begin
                    if (m_pre[i] == p_div[i] - 1) begin
                        add = 1;
                        m_pre[i] = 0;
                    end else begin
                        m_pre[i]++;
                    end
                end
                if (in_bv) add += ((in_amt > 4'd9) ? 9 : int'(in_amt)) * p10(p_bp[i]);
                s = m_score[i] + add;
                if (s >= lim) begin
                    m_ov[i] = 1;
                    m_score[i] = (p_wrap[i] != 0) ? s - lim : lim - 1;
                end else begin
                    m_score[i] = s;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [15:0] sc, hs;
        logic        ga, nh, ov;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin sc = a_score; hs = a_hi; ga = a_act; nh = a_nh; ov = a_ov; end
                1: begin sc = b_score; hs = b_hi; ga = b_act; nh = b_nh; ov = b_ov; end
                2: begin sc = c_score; hs = c_hi; ga = c_act; nh = c_nh; ov = c_ov; end
                default: begin
                    sc = {12'h0, d_score}; hs = {12'h0, d_hi};
                    ga = d_act; nh = d_nh; ov = d_ov;
                end
            endcase
            chk($sformatf("model_score[%0d]", i), 32'(sc), 32'(to_bcd(m_score[i])));
            chk($sformatf("model_hi[%0d]", i), 32'(hs), 32'(to_bcd(m_hi[i])));
            chk($sformatf("model_active[%0d]", i), 32'(ga), 32'(m_run[i]));
            chk($sformatf("model_new_high[%0d]", i), 32'(nh), 32'(m_nh[i]));
            chk($sformatf("model_overflow[%0d]", i), 32'(ov), 32'(m_ov[i]));
        end
    endtask

    // Drive one cycle's inputs (called at a negedge), clock, then check.
    task automatic cycle(input bit r, input bit s, input bit o, input bit t,
                         input bit bv, input logic [3:0] amt);
        in_rst = r; in_start = s; in_over = o; in_tick = t; in_bv = bv; in_amt = amt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_model();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 1, 0, 4'd0);
    endtask

    typedef struct {
        bit          rst, start, over, tick, bv;
        logic [3:0]  amt;
        logic [15:0] score, hi;
        bit          act, nh, ov;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Expected values for instance A (defaults).
        //          rst st ov tk bv amt    score     hi        act nh ov
        tbl[0]  = '{1, 0, 0, 0, 0, 4'd0,  16'h0000, 16'h0000, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 4'd0,  16'h0000, 16'h0000, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 4'd0,  16'h0001, 16'h0000, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 4'd3,  16'h0031, 16'h0000, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 1, 4'd15, 16'h0122, 16'h0000, 1, 0, 0};
        tbl[5]  = '{0, 1, 0, 1, 0, 4'd0,  16'h0000, 16'h0000, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 4'd0,  16'h0001, 16'h0000, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 4'd0,  16'h0001, 16'h0000, 1, 0, 0};
        tbl[8]  = '{0, 0, 1, 1, 0, 4'd0,  16'h0001, 16'h0001, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 4'd0,  16'h0001, 16'h0001, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 4'd0,  16'h0001, 16'h0001, 0, 1, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 4'd0,  16'h0000, 16'h0001, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 0, 4'd0,  16'h0000, 16'h0000, 0, 0, 0};

        @(negedge clk);
        for (int v = 0; v < 13; v++) begin
            cycle(tbl[v].rst, tbl[v].start, tbl[v].over, tbl[v].tick, tbl[v].bv, tbl[v].amt);
            chk($sformatf("tbl%0d_score", v), 32'(a_score), 32'(tbl[v].score));
            chk($sformatf("tbl%0d_hi", v), 32'(a_hi), 32'(tbl[v].hi));
            chk($sformatf("tbl%0d_active", v), 32'(a_act), 32'(tbl[v].act));
            chk($sformatf("tbl%0d_new_high", v), 32'(a_nh), 32'(tbl[v].nh));
            chk($sformatf("tbl%0d_overflow", v), 32'(a_ov), 32'(tbl[v].ov));
        end

        // Carry chain through three digits
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(999);
        chk("carry_preload", 32'(a_score), 32'h0999);
        cycle(0, 0, 0, 1, 1, 4'd3);
        chk("carry_tick_bonus", 32'(a_score), 32'h1030);

        // Overflow: saturate vs wrap
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(9998);
        chk("ovf_preload", 32'(a_score), 32'h9998);
        chk("ovf_preload_flag", 32'(a_ov), 32'h0);
        cycle(0, 0, 0, 0, 1, 4'd5);
        chk("sat_score", 32'(a_score), 32'h9999);
        chk("sat_flag", 32'(a_ov), 32'h1);
        chk("wrap_score", 32'(b_score), 32'h0048);
        chk("wrap_flag", 32'(b_ov), 32'h1);
        cycle(0, 0, 0, 1, 0, 4'd0);
        chk("sat_hold", 32'(a_score), 32'h9999);
        chk("wrap_after", 32'(b_score), 32'h0049);
        chk("wrap_flag_sticky", 32'(b_ov), 32'h1);
        cycle(0, 1, 0, 0, 0, 4'd0);
        chk("sat_flag_clear", 32'(a_ov), 32'h0);
        chk("wrap_flag_clear", 32'(b_ov), 32'h0);

        // Prescaler
        ticks(7);
        chk("presc_7", 32'(c_score), 32'h0002);
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(2);
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(2);
        chk("presc_restart", 32'(c_score), 32'h0000);

        // High score rules
        cycle(1, 0, 0, 0, 0, 4'd0);
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(50);
        cycle(0, 0, 1, 0, 0, 4'd0);
        chk("hi_game1", 32'(a_hi), 32'h0050);
        chk("hi_game1_nh", 32'(a_nh), 32'h1);
        cycle(0, 1, 0, 0, 0, 4'd0);
        chk("hi_start_nh_clear", 32'(a_nh), 32'h0);
        ticks(50);
        cycle(0, 0, 1, 0, 0, 4'd0);
        chk("hi_tie", 32'(a_hi), 32'h0050);
        chk("hi_tie_nh", 32'(a_nh), 32'h0);
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(49);
        cycle(0, 0, 1, 0, 0, 4'd0);
        chk("hi_lower", 32'(a_hi), 32'h0050);
        chk("hi_lower_nh", 32'(a_nh), 32'h0);
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(60);
        cycle(0, 1, 1, 0, 0, 4'd0);
        chk("start_over_active", 32'(a_act), 32'h1);
        chk("start_over_score", 32'(a_score), 32'h0000);
        chk("start_over_hi", 32'(a_hi), 32'h0050);

        // Reset mid-game, then ignored events in IDLE and OVER
        ticks(123);
        chk("rst_preload", 32'(a_score), 32'h0123);
        cycle(1, 0, 0, 1, 0, 4'd0);
        chk("rst_score", 32'(a_score), 32'h0000);
        chk("rst_hi", 32'(a_hi), 32'h0000);
        chk("rst_active", 32'(a_act), 32'h0);
        cycle(0, 0, 0, 1, 1, 4'd9);
        chk("idle_ignore", 32'(a_score), 32'h0000);
        cycle(0, 1, 0, 0, 0, 4'd0);
        ticks(5);
        cycle(0, 0, 1, 0, 0, 4'd0);
        cycle(0, 0, 0, 1, 1, 4'd9);
        chk("over_ignore", 32'(a_score), 32'h0005);

        // Randomized stream against the model
        for (int k = 0; k < 4000; k++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
